// File: rtl/core_pkg.sv
// Shared core types and constants: datapath/register-address widths and the
// issue-slot state encoding used by the operand fetch stage.
package core_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_addr_t ZERO_REG = '0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/operand_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register (x0 excluded),
// set on issue of a writing instruction, cleared by writeback or slot kill.
module operand_scoreboard #(
    parameter int NREGS = core_pkg::NREGS,
    parameter int AW    = core_pkg::AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic [AW-1:0] i_rs2_addr,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_uses_rs1,
    input  logic          i_uses_rs2,
    input  logic          i_rd_we,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_kill_addr,
    input  logic          i_kill_en,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy,
    output logic          o_rd_busy
);

    logic [NREGS-1:1] pend_q;
    logic [NREGS-1:1] pend_d;
    logic [NREGS-1:0] pend_full;

    // The set term is evaluated last so an issue beats a same-cycle clear.
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic clr;
            logic set;
            assign clr = (i_wb_en && (i_wb_addr == IDX)) ||
                         (i_kill_en && (i_kill_addr == IDX));
            assign set = i_set_en && i_rd_we && (i_rd_addr == IDX);
            assign pend_d[gi] = set | (pend_q[gi] & ~clr);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Bit 0 is tied low, so lookups of x0 can never report busy.
    assign pend_full = {pend_q, 1'b0};

    assign o_rs1_busy = i_uses_rs1 && pend_full[i_rs1_addr];
    assign o_rs2_busy = i_uses_rs2 && pend_full[i_rs2_addr];
    assign o_rd_busy  = i_rd_we    && pend_full[i_rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: hazard-checked issue of decoded instructions into a single
// registered slot. Define OPERAND_FETCH_WB_BYPASS_EN to forward writeback data.
module operand_fetch #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = core_pkg::NREGS,
    parameter int AW    = core_pkg::AW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_dec_valid,
    output logic            o_dec_ready,
    input  logic [AW-1:0]   i_dec_rs1_addr,
    input  logic [AW-1:0]   i_dec_rs2_addr,
    input  logic            i_dec_uses_rs1,
    input  logic            i_dec_uses_rs2,
    input  logic [AW-1:0]   i_dec_rd_addr,
    input  logic            i_dec_rd_we,
    output logic [AW-1:0]   o_rf_rs1_addr,
    output logic [AW-1:0]   o_rf_rs2_addr,
    input  logic [XLEN-1:0] i_rf_rs1_data,
    input  logic [XLEN-1:0] i_rf_rs2_data,
    input  logic [AW-1:0]   i_wb_rd_addr,
    input  logic [XLEN-1:0] i_wb_rd_data,
    input  logic            i_wb_write_en,
    input  logic            i_flush,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [AW-1:0]   o_ex_rd_addr,
    output logic            o_ex_rd_we,
    output logic            o_stall
);

    import core_pkg::*;

    localparam logic [AW-1:0] REG0 = AW'(ZERO_REG);

    slot_state_e     state_q, state_d;
    logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic            ex_rd_we_q, ex_rd_we_d;

    logic            rs1_busy, rs2_busy, rd_busy;
    logic            byp_rs1, byp_rs2;
    logic            raw_hazard, hazard;
    logic            slot_free, accept, kill_en;
    logic [XLEN-1:0] rs1_op, rs2_op;

    assign o_rf_rs1_addr = i_dec_rs1_addr;
    assign o_rf_rs2_addr = i_dec_rs2_addr;

    operand_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rs1_addr  (i_dec_rs1_addr),
        .i_rs2_addr  (i_dec_rs2_addr),
        .i_rd_addr   (i_dec_rd_addr),
        .i_uses_rs1  (i_dec_uses_rs1),
        .i_uses_rs2  (i_dec_uses_rs2),
        .i_rd_we     (i_dec_rd_we),
        .i_set_en    (accept),
        .i_wb_addr   (i_wb_rd_addr),
        .i_wb_en     (i_wb_write_en),
        .i_kill_addr (ex_rd_q),
        .i_kill_en   (kill_en),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_rd_busy   (rd_busy)
    );

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // A same-cycle writeback to a source register supplies the operand directly.
    assign byp_rs1 = i_wb_write_en && (i_wb_rd_addr == i_dec_rs1_addr) &&
                     (i_dec_rs1_addr != REG0);
    assign byp_rs2 = i_wb_write_en && (i_wb_rd_addr == i_dec_rs2_addr) &&
                     (i_dec_rs2_addr != REG0);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^i_wb_rd_data;
    assign byp_rs1 = 1'b0;
    assign byp_rs2 = 1'b0;
`endif

    assign raw_hazard = (rs1_busy && !byp_rs1) || (rs2_busy && !byp_rs2);
    assign hazard     = raw_hazard || rd_busy;
    assign slot_free  = (state_q == SLOT_EMPTY) || i_ex_ready;
    assign accept     = i_rst_n && i_dec_valid && slot_free && !hazard && !i_flush;
    assign kill_en    = i_flush && (state_q == SLOT_FULL) && ex_rd_we_q;

    assign o_dec_ready = accept;
    assign o_stall     = i_rst_n && i_dec_valid && hazard;

    always_comb begin
        rs1_op = i_rf_rs1_data;
        rs2_op = i_rf_rs2_data;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (byp_rs1) rs1_op = i_wb_rd_data;
        if (byp_rs2) rs2_op = i_wb_rd_data;
`endif
        if (i_dec_rs1_addr == REG0) rs1_op = '0;
        if (i_dec_rs2_addr == REG0) rs2_op = '0;
    end

    // Slot state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (i_flush)         state_d = SLOT_EMPTY;
                else if (accept)     state_d = SLOT_FULL;
                else if (i_ex_ready) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Slot outputs
    always_comb begin
        o_ex_valid = (state_q == SLOT_FULL);
    end

    always_comb begin
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_we_d = ex_rd_we_q;
        if (accept) begin
            ex_rs1_d   = rs1_op;
            ex_rs2_d   = rs2_op;
            ex_rd_d    = i_dec_rd_addr;
            ex_rd_we_d = i_dec_rd_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
        end else begin
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_we_q <= ex_rd_we_d;
        end
    end

    assign o_ex_rs1_data = ex_rs1_q;
    assign o_ex_rs2_data = ex_rs2_q;
    assign o_ex_rd_addr  = ex_rd_q;
    assign o_ex_rd_we    = ex_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: inputs change just after each negedge,
// outputs are checked 1 time unit later, well clear of the posedge.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        uses_rs1, uses_rs2, rd_we;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_en, flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_rs1, ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_rd_we, stall;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_dec_valid    (dec_valid),
        .o_dec_ready    (dec_ready),
        .i_dec_rs1_addr (rs1_addr),
        .i_dec_rs2_addr (rs2_addr),
        .i_dec_uses_rs1 (uses_rs1),
        .i_dec_uses_rs2 (uses_rs2),
        .i_dec_rd_addr  (rd_addr),
        .i_dec_rd_we    (rd_we),
        .o_rf_rs1_addr  (rf_rs1_addr),
        .o_rf_rs2_addr  (rf_rs2_addr),
        .i_rf_rs1_data  (rf_rs1_data),
        .i_rf_rs2_data  (rf_rs2_data),
        .i_wb_rd_addr   (wb_addr),
        .i_wb_rd_data   (wb_data),
        .i_wb_write_en  (wb_en),
        .i_flush        (flush),
        .o_ex_valid     (ex_valid),
        .i_ex_ready     (ex_ready),
        .o_ex_rs1_data  (ex_rs1),
        .o_ex_rs2_data  (ex_rs2),
        .o_ex_rd_addr   (ex_rd),
        .o_ex_rd_we     (ex_rd_we),
        .o_stall        (stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic dec(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic we);
        dec_valid = v;
        rs1_addr  = r1;
        uses_rs1  = u1;
        rs2_addr  = r2;
        uses_rs2  = u2;
        rd_addr   = rd;
        rd_we     = we;
    endtask

    // Advance to the next negedge (inputs are then driven by the caller).
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        rf_rs1_data = 32'hA; rf_rs2_data = 32'hB;
        dec(1, 5'd1, 1, 5'd2, 1, 5'd3, 1);

        // Reset held with a valid instruction waiting
        repeat (2) cyc();
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_dec_ready", {31'b0, dec_ready}, 32'd0);
        chk("rst_ex_rs1", ex_rs1, 32'd0);
        chk("rst_ex_rs2", ex_rs2, 32'd0);
        chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
        chk("rst_ex_rd_we", {31'b0, ex_rd_we}, 32'd0);
        chk("rf_addr_pass", {27'b0, rf_rs1_addr}, 32'd1);

        // Independent stream, rd = 3, 4, 6
        cyc(); rst_n = 1'b1; #1;
        chk("first_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(1, 5'd1, 1, 5'd2, 1, 5'd4, 1); #1;
        chk("s1_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("s1_ex_rs1", ex_rs1, 32'hA);
        chk("s1_ex_rs2", ex_rs2, 32'hB);
        chk("s1_ex_rd", {27'b0, ex_rd}, 32'd3);
        chk("s1_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(1, 5'd1, 1, 5'd2, 1, 5'd6, 1); #1;
        chk("s2_ex_rd", {27'b0, ex_rd}, 32'd4);
        chk("s2_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(1, 5'd3, 1, 5'd0, 0, 5'd0, 0); #1;
        chk("s3_ex_rd", {27'b0, ex_rd}, 32'd6);
        chk("pend3_stall", {31'b0, stall}, 32'd1);
        chk("pend3_no_accept", {31'b0, dec_ready}, 32'd0);
        cyc(); dec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); wb_en = 1'b1; wb_addr = 5'd3;
        cyc(); dec(1, 5'd3, 1, 5'd0, 0, 5'd0, 0); wb_addr = 5'd4; #1;
        chk("pend3_cleared", {31'b0, stall}, 32'd0);
        cyc(); dec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); wb_addr = 5'd6;
        cyc(); wb_en = 1'b0;

        // RAW on x5, writeback three cycles after issue
        cyc(); dec(1, 5'd1, 1, 5'd2, 1, 5'd5, 1); #1;
        chk("raw_issue_rd5", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(1, 5'd5, 1, 5'd0, 0, 5'd0, 0); #1;
        chk("raw_stall_c1", {31'b0, stall}, 32'd1);
        cyc(); #1;
        chk("raw_stall_c2", {31'b0, stall}, 32'd1);
        cyc(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; #1;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        chk("raw_wb_cycle_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); wb_en = 1'b0; dec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); #1;
        chk("raw_bypass_op", ex_rs1, 32'h1234);
`else
        chk("raw_wb_cycle_stall", {31'b0, stall}, 32'd1);
        cyc(); wb_en = 1'b0; rf_rs1_data = 32'h1234; #1;
        chk("raw_after_wb_stall", {31'b0, stall}, 32'd0);
        chk("raw_after_wb_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); #1;
        chk("raw_op", ex_rs1, 32'h1234);
`endif
        chk("raw_ex_valid", {31'b0, ex_valid}, 32'd1);

        // Backpressure: slot held for 4 cycles
        cyc(); rf_rs1_data = 32'hA; rf_rs2_data = 32'hB;
        dec(1, 5'd1, 1, 5'd2, 1, 5'd0, 0);
        cyc(); ex_ready = 1'b0; rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
        dec(1, 5'd2, 1, 5'd1, 1, 5'd0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #1;
            chk("bp_hold_rs1", ex_rs1, 32'hA);
            chk("bp_hold_rs2", ex_rs2, 32'hB);
            chk("bp_no_accept", {31'b0, dec_ready}, 32'd0);
        end
        cyc(); ex_ready = 1'b1; #1;
        chk("bp_resume_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(1, 5'd1, 1, 5'd2, 1, 5'd7, 1); #1;
        chk("bp_new_op", ex_rs1, 32'h11);

        // Flush of a full slot writing x7
        cyc(); ex_ready = 1'b0; dec(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
        chk("fl_slot_rd", {27'b0, ex_rd}, 32'd7);
        chk("fl_waw_before", {31'b0, stall}, 32'd1);
        cyc(); flush = 1'b1; ex_ready = 1'b1; dec(1, 5'd1, 1, 5'd2, 1, 5'd0, 0); #1;
        chk("fl_no_accept", {31'b0, dec_ready}, 32'd0);
        cyc(); flush = 1'b0; dec(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
        chk("fl_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("fl_no_waw", {31'b0, stall}, 32'd0);
        chk("fl_accept_x7", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); wb_en = 1'b1; wb_addr = 5'd7;
        cyc(); wb_en = 1'b0;

        // x0 sources read as zero; rd = 0 never blocks
        cyc(); rf_rs1_data = 32'hDEAD; rf_rs2_data = 32'hB;
        dec(1, 5'd0, 1, 5'd2, 1, 5'd0, 1); #1;
        chk("x0_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(1, 5'd0, 1, 5'd0, 1, 5'd0, 1); #1;
        chk("x0_op_rs1", ex_rs1, 32'd0);
        chk("x0_op_rs2", ex_rs2, 32'hB);
        chk("rd0_no_pend", {31'b0, dec_ready}, 32'd1);
        cyc(); dec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); #1;
        chk("x0_both_zero", ex_rs2, 32'd0);

        // Writeback-clear and issue-set of x9 in one cycle: set wins
        cyc(); dec(1, 5'd0, 0, 5'd0, 0, 5'd9, 1); wb_en = 1'b1; wb_addr = 5'd9; #1;
        chk("x9_accept", {31'b0, dec_ready}, 32'd1);
        cyc(); wb_en = 1'b0; dec(1, 5'd9, 1, 5'd0, 0, 5'd0, 0); #1;
        chk("x9_set_wins", {31'b0, stall}, 32'd1);

        // Reset mid-operation drops pending x9
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1; #1;
        chk("rst_mid_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_mid_pend_clear", {31'b0, stall}, 32'd0);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion of the integer register file in the pipelined core.
- Accepts decoded instructions, drives the register-file read addresses and tracks outstanding destination writes in a scoreboard.
- Holds issue while a RAW or WAW hazard exists, then registers the operands into a single-entry issue slot with a valid/ready handshake to execute.
- Observes the writeback port, using the same signals that drive the register-file write, to retire scoreboard entries.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural register count; x0 hardwired zero
AW, 5, register address width, equal to log2(NREGS)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_dec_valid  in  1  decoded instruction present
o_dec_ready  out  1  instruction accepted this cycle
i_dec_rs1_addr / i_dec_rs2_addr  in  AW  source addresses
i_dec_uses_rs1 / i_dec_uses_rs2  in  1  source actually read
i_dec_rd_addr  in  AW  destination address
i_dec_rd_we  in  1  instruction writes rd
o_rf_rs1_addr / o_rf_rs2_addr  out  AW  register-file read addresses (combinational pass-through of decode addresses)
i_rf_rs1_data / i_rf_rs2_data  in  XLEN  register-file combinational read data
i_wb_rd_addr  in  AW  writeback destination
i_wb_rd_data  in  XLEN  writeback data
i_wb_write_en  in  1  writeback strobe
i_flush  in  1  kill the instruction held in the issue slot
o_ex_valid  out  1  issue slot full
i_ex_ready  in  1  execute accepts the slot
o_ex_rs1_data / o_ex_rs2_data  out  XLEN  registered operands
o_ex_rd_addr  out  AW  registered destination
o_ex_rd_we  out  1  registered write flag
o_stall  out  1  i_dec_valid held back by a hazard

Behaviour:
- Reset (i_rst_n=0 at posedge): clears the scoreboard pend[NREGS-1:1] and o_ex_valid. Zeroes o_ex_rs1_data, o_ex_rs2_data, o_ex_rd_addr and o_ex_rd_we. Reset mid-operation discards the slot and all pending state.
- Slot FSM: EMPTY (o_ex_valid=0) and FULL (o_ex_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on i_ex_ready with no accept, or on i_flush.
  - FULL→FULL on i_ex_ready with accept (back-to-back, one instruction per cycle).
- Slot-free condition: EMPTY, or i_ex_ready=1.
- RAW hazard per source: uses=1, addr≠0 and pend[addr]=1.
- WAW hazard: rd_we=1, rd≠0 and pend[rd]=1. At most one outstanding write per register.
- Accept: o_dec_ready = i_dec_valid & slot free & no hazard & ~i_flush. o_stall = i_dec_valid & hazard.
- Issue latency: operands are sampled from i_rf_* at the accept edge and appear on o_ex_* the next cycle.
- x0: a source address of 0 yields an operand of 0 regardless of i_rf_* data.
- Scoreboard update per posedge:
  - Clear pend[i_wb_rd_addr] when i_wb_write_en=1 and the address ≠ 0.
  - Set pend[i_dec_rd_addr] on accept when rd_we=1 and rd ≠ 0.
  - Set and clear of the same register in one cycle: set wins.
  - Writeback to a register that is not pending: no effect.
- Flush: the slot is emptied next cycle. If the killed slot had rd_we=1, its pend bit is cleared. No accept occurs in the flush cycle.
- Held slot: o_ex_* are stable while o_ex_valid=1 and i_ex_ready=0.
- Without bypass, a writeback in the same cycle as a RAW check still counts as a hazard. The register file updates at that edge, so issue occurs the following cycle.

Optional Feature:
- Macro: OPERAND_FETCH_WB_BYPASS_EN.
- Defined: a RAW hazard is cancelled when i_wb_write_en=1 and i_wb_rd_addr equals the pending source address. The operand is taken from i_wb_rd_data, saving one cycle.
- Undefined: no bypass path; the behaviour is exactly as specified above.

Decomposition:
- Shared package core_pkg:
  - XLEN and AW constants.
  - reg_addr_t and word_t typedefs.
  - ZERO_REG constant.
- One sub-module: operand_scoreboard. It holds the pend vector, the set/clear/flush-clear logic and the hazard lookups, and outputs rs1_busy, rs2_busy and rd_busy.

Test Plan:
- Reset with i_dec_valid=1: while reset is active, o_ex_valid=0, o_dec_ready=0 and all o_ex_* are 0. First accept occurs on the cycle after reset releases.
- Independent stream (rs1=1, rs2=2, rd=3, i_ex_ready=1, rf data 0xA/0xB): one accept per cycle and o_ex_rs1/rs2=0xA/0xB one cycle later. pend[3] is set after the accept edge.
- RAW stall (rd=5 issued, next instruction reads x5, writeback of 5 with 0x1234 three cycles later):
  - Without macro: o_stall=1 until the writeback edge; issue the cycle after; o_ex_rs1_data=0x1234.
  - With macro: issue in the writeback cycle with 0x1234.
- Backpressure (i_ex_ready=0 for 4 cycles with FULL slot): o_ex_* stable, o_dec_ready=0; accept resumes in the cycle i_ex_ready returns to 1.
- Flush of a FULL slot with rd=7: o_ex_valid=0 next cycle and pend[7]=0; a following write to x7 is not WAW-stalled.
- x0 source with rf data 0xDEAD gives operand 0. rd=0 never sets pend. Simultaneous writeback-clear and accept-set on x9 leave pend[9]=1.
